mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 44 ++++
 rtl/mem_access_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response and data-bus signal bundle for mem_access_unit.
// The master modport is the unit; slave is the EX/WB stages plus the memory bus.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic [ADDR_W-1:0] vaddr;
  logic [31:0]       wdata;
  logic [31:0]       rt_old;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       rdata;
  logic              exc_adel;
  logic              exc_ades;
  logic              bus_err;
  logic [ADDR_W-1:0] bad_vaddr;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [3:0]        data_wstrb;
  logic [31:0]       data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       data_rdata;

  modport master (
    input  in_valid, op, vaddr, wdata, rt_old, out_ready,
    input  data_addr_ok, data_data_ok, data_rdata,
    output in_ready, out_valid, rdata, exc_adel, exc_ades, bus_err, bad_vaddr,
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata
  );

  modport slave (
    output in_valid, op, vaddr, wdata, rt_old, out_ready,
    output data_addr_ok, data_data_ok, data_rdata,
    input  in_ready, out_valid, rdata, exc_adel, exc_ades, bus_err, bad_vaddr,
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MIPS-style load/store unit: alignment check, byte-lane steering, one bus transaction
// per request with a WAIT timeout, and load result formatting including LWL/LWR merge.
module mem_access_unit #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic              clk,
  input logic              resetn,
  mem_access_unit_if.master bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  localparam logic [3:0] OpLw  = 4'd0;
  localparam logic [3:0] OpLb  = 4'd1;
  localparam logic [3:0] OpLbu = 4'd2;
  localparam logic [3:0] OpLh  = 4'd3;
  localparam logic [3:0] OpLhu = 4'd4;
  localparam logic [3:0] OpLwl = 4'd5;
  localparam logic [3:0] OpLwr = 4'd6;
  localparam logic [3:0] OpSw  = 4'd8;
  localparam logic [3:0] OpSb  = 4'd9;
  localparam logic [3:0] OpSh  = 4'd10;
  localparam logic [3:0] OpSwl = 4'd11;
  localparam logic [3:0] OpSwr = 4'd12;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OpLwr) || ((op >= OpSw) && (op <= OpSwr));
  endfunction

  function automatic logic op_store(input logic [3:0] op);
    return (op >= OpSw) && (op <= OpSwr);
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
    case (op)
      OpLh, OpLhu, OpSh: return a[0];
      OpLw, OpSw:        return a != 2'd0;
      default:           return 1'b0;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] vaddr_q, vaddr_d, bad_vaddr_q, bad_vaddr_d;
  logic [31:0]       wdata_q, wdata_d, rt_old_q, rt_old_d, rdata_q, rdata_d;
  logic              adel_q, adel_d, ades_q, ades_d, berr_q, berr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       load_data;
  logic [1:0]        a;

  assign a = vaddr_q[1:0];

  // Load result formatting from the raw bus word; r is the old rt for partial-word merges.
  always_comb begin
    logic [31:0] m, r, m_sh;
    logic [15:0] half;
    m         = bus.data_rdata;
    r         = rt_old_q;
    m_sh      = m >> {a, 3'b000};
    half      = a[1] ? m[31:16] : m[15:0];
    load_data = 32'd0;
    case (op_q)
      OpLb:  load_data = {{24{m_sh[7]}}, m_sh[7:0]};
      OpLbu: load_data = {24'd0, m_sh[7:0]};
      OpLh:  load_data = {{16{half[15]}}, half};
      OpLhu: load_data = {16'd0, half};
      OpLw:  load_data = m;
      OpLwl: begin
        unique case (a)
          2'd0: load_data = {m[7:0], r[23:0]};
          2'd1: load_data = {m[15:0], r[15:0]};
          2'd2: load_data = {m[23:0], r[7:0]};
          2'd3: load_data = m;
        endcase
      end
      OpLwr: begin
        unique case (a)
          2'd0: load_data = m;
          2'd1: load_data = {r[31:24], m[31:8]};
          2'd2: load_data = {r[31:16], m[31:16]};
          2'd3: load_data = {r[31:8], m[31:24]};
        endcase
      end
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    vaddr_d     = vaddr_q;
    wdata_d     = wdata_q;
    rt_old_d    = rt_old_q;
    rdata_d     = rdata_q;
    adel_d      = adel_q;
    ades_d      = ades_q;
    berr_d      = berr_q;
    bad_vaddr_d = bad_vaddr_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          op_d        = bus.op;
          vaddr_d     = bus.vaddr;
          wdata_d     = bus.wdata;
          rt_old_d    = bus.rt_old;
          rdata_d     = 32'd0;
          adel_d      = 1'b0;
          ades_d      = 1'b0;
          berr_d      = 1'b0;
          bad_vaddr_d = '0;
          if (!op_legal(bus.op)) begin
            state_d = StResp;
          end else if (misaligned(bus.op, bus.vaddr[1:0])) begin
            adel_d      = !op_store(bus.op);
            ades_d      = op_store(bus.op);
            bad_vaddr_d = bus.vaddr;
            state_d     = StResp;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (bus.data_addr_ok) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        if (bus.data_data_ok) begin
          state_d = StResp;
          rdata_d = op_store(op_q) ? 32'd0 : load_data;
        end else if (cnt_q == CntLast) begin
          state_d = StResp;
          berr_d  = 1'b1;
          rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      op_q        <= 4'd0;
      vaddr_q     <= '0;
      wdata_q     <= 32'd0;
      rt_old_q    <= 32'd0;
      rdata_q     <= 32'd0;
      adel_q      <= 1'b0;
      ades_q      <= 1'b0;
      berr_q      <= 1'b0;
      bad_vaddr_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      vaddr_q     <= vaddr_d;
      wdata_q     <= wdata_d;
      rt_old_q    <= rt_old_d;
      rdata_q     <= rdata_d;
      adel_q      <= adel_d;
      ades_q      <= ades_d;
      berr_q      <= berr_d;
      bad_vaddr_q <= bad_vaddr_d;
      cnt_q       <= cnt_d;
    end
  end

  // Bus lane steering, decoded from the captured request only.
  always_comb begin
    bus.data_size  = 2'd2;
    bus.data_addr  = {vaddr_q[ADDR_W-1:2], 2'b00};
    bus.data_wstrb = 4'b0000;
    bus.data_wdata = 32'd0;
    case (op_q)
      OpLb, OpLbu: begin
        bus.data_size = 2'd0;
        bus.data_addr = vaddr_q;
      end
      OpLh, OpLhu: begin
        bus.data_size = 2'd1;
        bus.data_addr = vaddr_q;
      end
      OpSb: begin
        bus.data_size  = 2'd0;
        bus.data_addr  = vaddr_q;
        bus.data_wstrb = 4'b0001 << a;
        bus.data_wdata = {4{wdata_q[7:0]}};
      end
      OpSh: begin
        bus.data_size  = 2'd1;
        bus.data_addr  = vaddr_q;
        bus.data_wstrb = a[1] ? 4'b1100 : 4'b0011;
        bus.data_wdata = {2{wdata_q[15:0]}};
      end
      OpSw: begin
        bus.data_wstrb = 4'b1111;
        bus.data_wdata = wdata_q;
      end
      OpSwl: begin
        bus.data_wstrb = 4'b1111 >> (2'd3 - a);
        bus.data_wdata = wdata_q >> {2'd3 - a, 3'b000};
      end
      OpSwr: begin
        bus.data_wstrb = 4'b1111 << a;
        bus.data_wdata = wdata_q << {a, 3'b000};
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StResp);
  assign bus.data_req  = (state_q == StReq);
  assign bus.data_wr   = op_store(op_q);
  assign bus.rdata     = rdata_q;
  assign bus.exc_adel  = adel_q;
  assign bus.exc_ades  = ades_q;
  assign bus.bus_err   = berr_q;
  assign bus.bad_vaddr = bad_vaddr_q;

endmodule
